// File: rtl/grid_swap_pkg.sv
// Shared constants, state encoding and swap-legality rule for the grid swap engine.
// Defaults describe the classic 3x3 quiz grid; the engine may be instantiated larger.
package grid_swap_pkg;

   localparam int DEF_DW       = 6;
   localparam int DEF_ROWS     = 3;
   localparam int DEF_COLS     = 3;
   localparam int DEF_MQ_DEPTH = 16;

   localparam int N      = DEF_ROWS * DEF_COLS;
   localparam int CIDX_W = (N > 1) ? $clog2(N) : 1;
   localparam int MW     = 1 + CIDX_W;

   localparam logic DIR_RIGHT = 1'b0;
   localparam logic DIR_DOWN  = 1'b1;

   typedef enum logic [1:0] {LOAD, SWAP, OUT} state_e;

   // A swap is legal only when both cells lie on the grid and a right swap does not wrap rows.
   function automatic logic is_legal(logic dir, int unsigned idx,
                                     int unsigned rows = DEF_ROWS,
                                     int unsigned cols = DEF_COLS);
      if (dir == DIR_RIGHT)
         return (idx < rows * cols) && ((idx % cols) != (cols - 1));
      return (idx + cols) < (rows * cols);
   endfunction

endpackage

// File: rtl/grid_mode_fifo.sv
// Synchronous FIFO holding queued swap commands; one extra pointer bit separates full from empty.
module grid_mode_fifo #(
   parameter int MW       = 5,
   parameter int MQ_DEPTH = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push_i,
   input  logic [MW-1:0] din_i,
   input  logic          pop_i,
   output logic [MW-1:0] dout_o,
   output logic          full_o,
   output logic          empty_o
);
   localparam int AW = $clog2(MQ_DEPTH);

   logic [MW-1:0] mem_q [MQ_DEPTH];
   logic [AW:0]   wr_q, rd_q;

   assign empty_o = (wr_q == rd_q);
   assign full_o  = (wr_q == {~rd_q[AW], rd_q[AW-1:0]});
   assign dout_o  = mem_q[rd_q[AW-1:0]];

   // NOTE: storage is deliberately not reset; only entries between the pointers are ever read.
   always_ff @(posedge clk) begin
      if (push_i && !full_o) mem_q[wr_q[AW-1:0]] <= din_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (push_i && !full_o) wr_q <= wr_q + 1'b1;
         if (pop_i && !empty_o) rd_q <= rd_q + 1'b1;
      end
   end

endmodule

// File: rtl/grid_swap_engine.sv
// Loads unique tokens into a row-major grid, applies queued swaps one per cycle,
// then streams the grid out serially before returning to the load phase.
module grid_swap_engine
   import grid_swap_pkg::*;
#(
   parameter int  DW       = DEF_DW,
   parameter int  ROWS     = DEF_ROWS,
   parameter int  COLS     = DEF_COLS,
   parameter int  MQ_DEPTH = DEF_MQ_DEPTH,
   localparam int NCELL    = ROWS * COLS,
   localparam int IDX_W    = (NCELL > 1) ? $clog2(NCELL) : 1,
   localparam int MODE_W   = 1 + IDX_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid1,
   input  logic [DW-1:0]     in,
   input  logic              in_valid2,
   input  logic [MODE_W-1:0] mode,
   output logic              out_valid,
   output logic [DW-1:0]     out,
   output logic              busy,
   output logic              mode_ovf,
   output logic              illegal
);
   localparam int CNT_W = $clog2(NCELL + 1);

   state_e            state_q, state_d;
   logic [DW-1:0]     grid_q [NCELL];
   logic [DW-1:0]     grid_d [NCELL];
   logic [2**DW-1:0]  seen_q, seen_d;
   logic [CNT_W-1:0]  fill_q, fill_d, ocnt_q, ocnt_d;
   logic [DW-1:0]     out_q, out_d;
   logic              out_valid_q, out_valid_d;
   logic              ovf_q, ovf_d;
   logic              illegal_q, illegal_d;

   logic              push, pop, q_full, q_empty;
   logic [MODE_W-1:0] q_mode;
   logic [IDX_W-1:0]  idx_a, idx_b;

   grid_mode_fifo #(.MW(MODE_W), .MQ_DEPTH(MQ_DEPTH)) u_mode_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .din_i   (mode),
      .pop_i   (pop),
      .dout_o  (q_mode),
      .full_o  (q_full),
      .empty_o (q_empty)
   );

   // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
   always_comb begin
      state_d     = state_q;
      grid_d      = grid_q;
      seen_d      = seen_q;
      fill_d      = fill_q;
      ocnt_d      = ocnt_q;
      out_d       = '0;
      out_valid_d = 1'b0;
      ovf_d       = ovf_q;
      illegal_d   = 1'b0;
      push        = 1'b0;
      pop         = 1'b0;
      idx_a       = q_mode[IDX_W-1:0];
      idx_b       = (q_mode[MODE_W-1] == DIR_DOWN) ? idx_a + IDX_W'(COLS) : idx_a + 1'b1;

      unique case (state_q)
         LOAD: begin
            if (in_valid1) begin
               if (in == '0) begin
                  state_d = SWAP;
               end else if (!seen_q[in] && fill_q < CNT_W'(NCELL)) begin
                  grid_d[fill_q[IDX_W-1:0]] = in;
                  seen_d[in]                = 1'b1;
                  fill_d                    = fill_q + 1'b1;
               end
            end
            // Mode queueing is independent of the token path, including the terminator cycle.
            if (in_valid2) begin
               if (q_full) ovf_d = 1'b1;
               else        push  = 1'b1;
            end
         end
         SWAP: begin
            if (q_empty) begin
               state_d = OUT;
            end else begin
               pop = 1'b1;
               if (is_legal(q_mode[MODE_W-1], int'(idx_a), ROWS, COLS)) begin
                  grid_d[idx_a] = grid_q[idx_b];
                  grid_d[idx_b] = grid_q[idx_a];
               end else begin
                  illegal_d = 1'b1;
               end
            end
         end
         OUT: begin
            if (ocnt_q < CNT_W'(NCELL)) begin
               out_valid_d = 1'b1;
               out_d       = grid_q[ocnt_q[IDX_W-1:0]];
               ocnt_d      = ocnt_q + 1'b1;
            end else begin
               state_d = LOAD;
               grid_d  = '{default: '0};
               seen_d  = '0;
               fill_d  = '0;
               ocnt_d  = '0;
               ovf_d   = 1'b0;
            end
         end
         default: state_d = LOAD;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= LOAD;
         grid_q      <= '{default: '0};
         seen_q      <= '0;
         fill_q      <= '0;
         ocnt_q      <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         ovf_q       <= 1'b0;
         illegal_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         grid_q      <= grid_d;
         seen_q      <= seen_d;
         fill_q      <= fill_d;
         ocnt_q      <= ocnt_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         ovf_q       <= ovf_d;
         illegal_q   <= illegal_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out       = out_q;
   assign busy      = (state_q != LOAD);
   assign mode_ovf  = ovf_q;
   assign illegal   = illegal_q;

endmodule

// File: tb/tb_grid_swap_engine.sv
// Directed bench for grid_swap_engine: table of load/mode/expected-grid vectors plus
// hand-written reset and busy-ignore sequences.
module tb_grid_swap_engine;
   import grid_swap_pkg::*;

   localparam int DW = DEF_DW;

   typedef struct packed {
      logic [0:11][DW-1:0] tok;
      int                  ntok;
      logic [0:19][MW-1:0] modes;
      int                  nmode;
      logic [0:N-1][DW-1:0] exp;
      int                  lat;
      int                  ill;
      logic                ovf;
      logic                noise;
   } vec_t;

   logic          clk;
   logic          rst_n;
   logic          in_valid1;
   logic [DW-1:0] in_tok;
   logic          in_valid2;
   logic [MW-1:0] mode;
   logic          out_valid;
   logic [DW-1:0] out_tok;
   logic          busy;
   logic          mode_ovf;
   logic          illegal;

   int   n_cmp = 0;
   int   n_bad = 0;
   vec_t vecs[$];

   grid_swap_engine dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid1 (in_valid1),
      .in        (in_tok),
      .in_valid2 (in_valid2),
      .mode      (mode),
      .out_valid (out_valid),
      .out       (out_tok),
      .busy      (busy),
      .mode_ovf  (mode_ovf),
      .illegal   (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic add_vec(input int t[12], input int nt, input int m[20], input int nm,
                          input int e[N], input int lat, input int ill,
                          input logic ovf, input logic noise);
      vec_t v;
      v = '0;
      for (int i = 0; i < 12; i++) v.tok[i] = DW'(t[i]);
      for (int i = 0; i < 20; i++) v.modes[i] = MW'(m[i]);
      for (int i = 0; i < N; i++) v.exp[i] = DW'(e[i]);
      v.ntok  = nt;
      v.nmode = nm;
      v.lat   = lat;
      v.ill   = ill;
      v.ovf   = ovf;
      v.noise = noise;
      vecs.push_back(v);
   endtask

   // Tokens and modes are both aligned to end on the terminator cycle.
   task automatic load_vec(input vec_t v);
      int ncyc = (v.ntok > v.nmode) ? v.ntok : v.nmode;
      for (int c = 0; c < ncyc; c++) begin
         int ti, mi;
         ti = c - (ncyc - v.ntok);
         mi = c - (ncyc - v.nmode);
         in_valid1 = 1'b0; in_tok = '0; in_valid2 = 1'b0; mode = '0;
         if (ti >= 0) begin in_valid1 = 1'b1; in_tok = v.tok[ti]; end
         if (mi >= 0) begin in_valid2 = 1'b1; mode = v.modes[mi]; end
         @(posedge clk); #1;
      end
      in_valid1 = v.noise;
      in_tok    = v.noise ? DW'(7) : '0;
      in_valid2 = v.noise;
      mode      = '0;
   endtask

   task automatic check_out(input vec_t v, input string nm);
      int k;
      int ill;
      check({nm, " busy"}, 32'(busy), 1);
      check({nm, " ovf"}, 32'(mode_ovf), 32'(v.ovf));
      k = 0;
      ill = 0;
      while (!out_valid && k < 200) begin
         @(posedge clk); #1;
         k++;
         if (illegal) ill++;
      end
      check({nm, " latency"}, k, v.lat);
      if (out_valid) begin
         for (int i = 0; i < N; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            check($sformatf("%s out[%0d]", nm, i), 32'(out_tok), 32'(v.exp[i]));
            check($sformatf("%s valid[%0d]", nm, i), 32'(out_valid), 1);
         end
         @(posedge clk); #1;
         check({nm, " idle valid"}, 32'(out_valid), 0);
         check({nm, " idle out"}, 32'(out_tok), 0);
         check({nm, " idle busy"}, 32'(busy), 0);
         check({nm, " ovf cleared"}, 32'(mode_ovf), 0);
      end
      check({nm, " illegal pulses"}, ill, v.ill);
      in_valid1 = 1'b0; in_tok = '0; in_valid2 = 1'b0; mode = '0;
   endtask

   initial begin
      int k;
      rst_n = 1'b0; in_valid1 = 1'b0; in_tok = '0; in_valid2 = 1'b0; mode = '0;

      // tokens, ntok, modes, nmode, expected grid, latency, illegal pulses, ovf, busy-noise
      add_vec('{5,3,7,1,2,4,6,8,9,0,0,0}, 10, '{0: 5'b0_0000, default: 0}, 1,
              '{3,5,7,1,2,4,6,8,9}, 3, 0, 1'b0, 1'b0);
      add_vec('{5,3,7,1,2,4,6,8,9,0,0,0}, 10, '{0: 5'b1_0000, 1: 5'b1_0011, default: 0}, 2,
              '{1,3,7,6,2,4,5,8,9}, 4, 0, 1'b0, 1'b0);
      add_vec('{5,3,7,1,2,4,6,8,9,0,0,0}, 10,
              '{0: 5'b0_0010, 1: 5'b1_0111, 2: 5'b0_1100, default: 0}, 3,
              '{5,3,7,1,2,4,6,8,9}, 5, 3, 1'b0, 1'b0);
      add_vec('{4,4,9,0,0,0,0,0,0,0,0,0}, 4, '{default: 0}, 0,
              '{4,9,0,0,0,0,0,0,0}, 2, 0, 1'b0, 1'b1);
      add_vec('{5,3,7,1,2,4,6,8,9,0,0,0}, 10, '{default: 0}, 17,
              '{5,3,7,1,2,4,6,8,9}, 18, 0, 1'b1, 1'b0);
      add_vec('{9,8,7,6,5,4,3,2,1,10,0,0}, 11, '{0: 5'b1_0101, 1: 5'b0_0111, default: 0}, 2,
              '{9,8,7,6,5,1,3,4,2}, 4, 0, 1'b0, 1'b0);

      #1;
      check("reset out_valid", 32'(out_valid), 0);
      check("reset out", 32'(out_tok), 0);
      check("reset busy", 32'(busy), 0);
      check("reset mode_ovf", 32'(mode_ovf), 0);
      check("reset illegal", 32'(illegal), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      foreach (vecs[i]) begin
         load_vec(vecs[i]);
         check_out(vecs[i], $sformatf("vec%0d", i));
      end

      // Asynchronous reset on the fourth output cycle, then a fresh load.
      load_vec(vecs[0]);
      k = 0;
      while (!out_valid && k < 200) begin @(posedge clk); #1; k++; end
      check("rst latency", k, 3);
      repeat (3) begin @(posedge clk); #1; end
      check("rst 4th out", 32'(out_tok), 1);
      check("rst 4th valid", 32'(out_valid), 1);
      #2 rst_n = 1'b0;
      #1;
      check("rst mid out_valid", 32'(out_valid), 0);
      check("rst mid out", 32'(out_tok), 0);
      check("rst mid busy", 32'(busy), 0);
      check("rst mid mode_ovf", 32'(mode_ovf), 0);
      check("rst mid illegal", 32'(illegal), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      load_vec(vecs[3]);
      check_out(vecs[3], "post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
